mdu_unit: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core; sits in the EX stage beside the ALU.
- Executes mult, multu, div, divu, madd, maddu, msub, msubu, mthi and mtlo.
- Operand width and latencies are parametrised.
- Exposes busy and a stall request so the hazard unit can freeze the pipeline on md-class instructions and mfhi/mflo.

---
 rtl/mdu_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_mdu_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : mdu_unit
// Description : Multi-cycle multiply/divide unit with HI/LO registers for the
//               EX stage of the pipelined MIPS core. Supports mult, multu,
//               div, divu, madd, maddu, msub, msubu, mthi and mtlo. The full
//               result is computed at issue, held in a pending register, and
//               committed to HI/LO after a fixed busy latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_LAT = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LAT  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
    localparam logic [3:0] c_OP_MADD  = 4'd7;
    localparam logic [3:0] c_OP_MADDU = 4'd8;
    localparam logic [3:0] c_OP_MSUB  = 4'd9;
    localparam logic [3:0] c_OP_MSUBU = 4'd10;

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_BUSY = 1'b1;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_pend;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_is_mul;
    logic                 w_is_div;
    logic                 w_is_signed;
    logic                 w_acc_add;
    logic                 w_acc_sub;
    logic                 w_is_mthi;
    logic                 w_is_mtlo;

    logic                 w_idle;
    logic                 w_issue;
    logic                 w_wr_hi;
    logic                 w_wr_lo;
    logic                 w_commit;

    logic [2*WIDTH-1:0]   w_hilo;
    logic [2*WIDTH-1:0]   w_a_ext;
    logic [2*WIDTH-1:0]   w_b_ext;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_mul_res;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic                 w_b_zero;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH-1:0]     w_b_mag_safe;
    logic [WIDTH-1:0]     w_q_mag;
    logic [WIDTH-1:0]     w_r_mag;
    logic [WIDTH-1:0]     w_q;
    logic [WIDTH-1:0]     w_r;
    logic [2*WIDTH-1:0]   w_div_res;

    // ------------------------------------------------------------------------
    // Opcode decode; reserved codes decode to nothing
    // ------------------------------------------------------------------------
    always_comb begin
        w_is_mul    = 1'b0;
        w_is_div    = 1'b0;
        w_is_signed = 1'b0;
        w_acc_add   = 1'b0;
        w_acc_sub   = 1'b0;
        w_is_mthi   = 1'b0;
        w_is_mtlo   = 1'b0;
        case (op)
            c_OP_MULT:  begin w_is_mul = 1'b1; w_is_signed = 1'b1; end
            c_OP_MULTU: begin w_is_mul = 1'b1; end
            c_OP_DIV:   begin w_is_div = 1'b1; w_is_signed = 1'b1; end
            c_OP_DIVU:  begin w_is_div = 1'b1; end
            c_OP_MTHI:  begin w_is_mthi = 1'b1; end
            c_OP_MTLO:  begin w_is_mtlo = 1'b1; end
            c_OP_MADD:  begin w_is_mul = 1'b1; w_is_signed = 1'b1; w_acc_add = 1'b1; end
            c_OP_MADDU: begin w_is_mul = 1'b1; w_acc_add = 1'b1; end
            c_OP_MSUB:  begin w_is_mul = 1'b1; w_is_signed = 1'b1; w_acc_sub = 1'b1; end
            c_OP_MSUBU: begin w_is_mul = 1'b1; w_acc_sub = 1'b1; end
            default:    begin end
        endcase
    end

    // ------------------------------------------------------------------------
    // Multiply / multiply-accumulate datapath. Sign- or zero-extending both
    // operands to 2*WIDTH lets one unsigned multiplier serve both flavours:
    // the low 2*WIDTH bits of the product are the same either way.
    // ------------------------------------------------------------------------
    assign w_hilo  = {r_hi, r_lo};
    assign w_a_ext = {{WIDTH{w_is_signed & A[WIDTH-1]}}, A};
    assign w_b_ext = {{WIDTH{w_is_signed & B[WIDTH-1]}}, B};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_mul_res = w_acc_add ? (w_hilo + w_prod) :
                       w_acc_sub ? (w_hilo - w_prod) :
                                   w_prod;

    // ------------------------------------------------------------------------
    // Divide datapath on magnitudes. MIN / -1 needs no special case: the
    // quotient magnitude 2^(WIDTH-1) is not negated (both signs negative) and
    // reads back as MIN, with a zero remainder. A zero divisor is replaced by
    // one to keep the divider well defined; its result is discarded anyway.
    // ------------------------------------------------------------------------
    assign w_a_neg      = w_is_signed & A[WIDTH-1];
    assign w_b_neg      = w_is_signed & B[WIDTH-1];
    assign w_b_zero     = (B == '0);
    assign w_a_mag      = w_a_neg ? (-A) : A;
    assign w_b_mag      = w_b_neg ? (-B) : B;
    assign w_b_mag_safe = w_b_zero ? WIDTH'(1) : w_b_mag;
    assign w_q_mag      = w_a_mag / w_b_mag_safe;
    assign w_r_mag      = w_a_mag % w_b_mag_safe;
    assign w_q          = (w_a_neg ^ w_b_neg) ? (-w_q_mag) : w_q_mag;
    assign w_r          = w_a_neg ? (-w_r_mag) : w_r_mag;

    // Divide by zero re-commits the current HI/LO; nothing can write HI/LO
    // while busy, so the commit leaves them unchanged.
    assign w_div_res = w_b_zero ? w_hilo : {w_r, w_q};

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start && (w_is_mul || w_is_div)) begin
                    w_state_nxt = c_S_BUSY;
                end
            end
            c_S_BUSY: begin
                if (r_cnt <= c_CNT_ONE) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM outputs and control strobes; starts while busy are dropped here
    // ------------------------------------------------------------------------
    always_comb begin
        w_idle   = (r_state == c_S_IDLE);
        w_issue  = w_idle & start & (w_is_mul | w_is_div);
        w_wr_hi  = w_idle & start & w_is_mthi;
        w_wr_lo  = w_idle & start & w_is_mtlo;
        w_commit = (r_state == c_S_BUSY) & (r_cnt <= c_CNT_ONE);
    end

    assign busy      = (r_state == c_S_BUSY);
    assign stall_req = busy | (start & (w_is_mul | w_is_div));

    // ------------------------------------------------------------------------
    // Latency counter: loaded at issue, counts down while busy
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= c_CNT_ZERO;
        end else if (w_issue) begin
            r_cnt <= w_is_div ? c_DIV_LAT : c_MULT_LAT;
        end else if (busy && (r_cnt != c_CNT_ZERO)) begin
            r_cnt <= r_cnt - c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Pending result captured at issue from the operands sampled that edge
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend <= '0;
        end else if (w_issue) begin
            r_pend <= w_is_div ? w_div_res : w_mul_res;
        end
    end

    // ------------------------------------------------------------------------
    // HI/LO architectural registers: commit or direct mthi/mtlo writes
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= r_pend[2*WIDTH-1:WIDTH];
            r_lo <= r_pend[WIDTH-1:0];
        end else begin
            if (w_wr_hi) begin
                r_hi <= A;
            end
            if (w_wr_lo) begin
                r_lo <= A;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_unit
// Description : Self-checking bench for mdu_unit. Directed scenarios followed
//               by randomized operations compared against an arithmetic
//               reference model of HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;

    localparam int c_W  = 32;
    localparam int c_ML = 5;
    localparam int c_DL = 10;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [3:0]     op    = 4'd0;
    logic [c_W-1:0] A     = '0;
    logic [c_W-1:0] B     = '0;
    logic           busy;
    logic           stall_req;
    logic [c_W-1:0] hi;
    logic [c_W-1:0] lo;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_hl   = '0;

    mdu_unit #(
        .WIDTH       (c_W),
        .MULT_CYCLES (c_ML),
        .DIV_CYCLES  (c_DL)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_md(input logic [3:0] o);
        return (o == 4'd1) || (o == 4'd2) || (o == 4'd3) || (o == 4'd4) ||
               (o == 4'd7) || (o == 4'd8) || (o == 4'd9) || (o == 4'd10);
    endfunction

    function automatic int latency(input logic [3:0] o);
        if (o == 4'd3 || o == 4'd4) return c_DL;
        if (is_md(o)) return c_ML;
        return 0;
    endfunction

    // Reference model of {hi,lo} after one operation, in plain arithmetic
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sa;
        int                 sb;
        logic [31:0]        q;
        logic [31:0]        r;
        sa = a;
        sb = b;
        sp = longint'(sa) * longint'(sb);
        up = {32'd0, a} * {32'd0, b};
        case (o)
            4'd1:  return sp;
            4'd2:  return up;
            4'd7:  return hl + sp;
            4'd8:  return hl + up;
            4'd9:  return hl - sp;
            4'd10: return hl - up;
            4'd3: begin
                if (b == 32'd0) return hl;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            4'd4: begin
                if (b == 32'd0) return hl;
                return {a % b, a / b};
            end
            4'd5:  return {a, hl[31:0]};
            4'd6:  return {hl[63:32], a};
            default: return hl;
        endcase
    endfunction

    // Issue one op from IDLE; optionally poke an ignored start mid-flight
    task automatic run_op(input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
        int lat;
        int inj_cyc;
        lat     = latency(o);
        inj_cyc = (lat > 0) ? $urandom_range(1, lat) : 0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        #1;
        check("stall_issue", 64'(stall_req), 64'(is_md(o)));
        exp_hl = model(o, a, b, exp_hl);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            start = 1'b0;
            op    = 4'd0;
            check("busy", 64'(busy), 64'd1);
            if (inject && i == inj_cyc) begin
                start = 1'b1;
                op    = 4'($urandom_range(1, 15));
                A     = $urandom;
                B     = $urandom;
            end
            #1;
            check("stall_busy", 64'(stall_req), 64'd1);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 4'd0;
        check("done_busy", 64'(busy), 64'd0);
        #1;
        check("done_stall", 64'(stall_req), 64'd0);
        check("hi", 64'(hi), {32'd0, exp_hl[63:32]});
        check("lo", 64'(lo), {32'd0, exp_hl[31:0]});
    endtask

    // Reset during busy cycle 3 of a mult; no late commit may follow
    task automatic reset_mid_mult(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = 4'd1;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        op    = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
        exp_hl = '0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        for (int i = 0; i < c_ML + 3; i++) begin
            @(negedge clk);
            check("rst_no_commit", {hi, lo}, 64'd0);
            check("rst_idle", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        logic [3:0]  o;
        logic [31:0] a;
        logic [31:0] b;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_stall", 64'(stall_req), 64'd0);
        reset = 1'b1;

        // Directed scenarios with literal expectations
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("tp_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("tp_multu", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("tp_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'd4, 32'd7, 32'd2, 1'b0);
        check("tp_divu", {hi, lo}, 64'h0000_0001_0000_0003);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("tp_div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(4'd5, 32'h1234_5678, 32'd0, 1'b0);
        run_op(4'd6, 32'h0000_0001, 32'd0, 1'b0);
        check("tp_mthi_mtlo", {hi, lo}, 64'h1234_5678_0000_0001);
        run_op(4'd7, 32'd2, 32'd3, 1'b0);
        check("tp_madd", {hi, lo}, 64'h1234_5678_0000_0007);
        run_op(4'd10, 32'd1, 32'd8, 1'b0);
        check("tp_msubu", {hi, lo}, 64'h1234_5677_FFFF_FFFF);
        run_op(4'd5, 32'h0000_00AA, 32'd0, 1'b0);
        run_op(4'd6, 32'h0000_00BB, 32'd0, 1'b0);
        run_op(4'd4, 32'd5, 32'd0, 1'b0);
        check("tp_divu_zero", {hi, lo}, 64'h0000_00AA_0000_00BB);
        run_op(4'd1, 32'd6, 32'd7, 1'b1);
        check("tp_ignore", {hi, lo}, 64'h0000_0000_0000_002A);
        reset_mid_mult(32'd9, 32'd9);

        // Randomized operations
        for (int n = 0; n < 150; n++) begin
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                1: b = 32'd0;
                2: begin a = 32'($urandom_range(0, 20)); b = 32'($urandom_range(0, 5)); end
                3: begin a = -32'($urandom_range(1, 20)); b = 32'($urandom_range(1, 5)); end
                default: begin end
            endcase
            if ($urandom_range(0, 39) == 0) begin
                reset_mid_mult(a, b);
            end else begin
                run_op(o, a, b, ($urandom_range(0, 3) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
